// File: rtl/dpd_capture.sv
// dpd_capture: snapshot of N time-aligned reference/feedback sample pairs.
// The block records N pairs into one N x 2W memory, then plays them back
// in index order over a valid/ready interface. The synchronous read
// latency is hidden by re-reading the presented address while the
// consumer stalls.
// rst_n is expected to be released synchronously to clk by the reset
// tree. A local synchroniser would delay the first start past the
// first edge after release, so there is none here.
// AW must equal log2(N).
module dpd_capture #(
  parameter int W  = 16,
  parameter int N  = 1024,
  parameter int AW = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] ref_in,
  input  logic [W-1:0] fb_in,
  input  logic         in_valid,
  input  logic         start,
  input  logic         abort,
  output logic [W-1:0] out_ref,
  output logic [W-1:0] out_fb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READ    = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_addr;
  logic [2*W-1:0]  mem [N];
  logic [2*W-1:0]  rd_q;
  logic            out_valid_q;
  logic            done_q;
  logic            wr_en;
  logic            wr_last;
  logic            rd_en;
  logic            accept;
  logic            rd_last;

  // Datapath strobes derived from the current state and handshakes.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en   = (state_q == CAPTURE) && in_valid && !abort;
    wr_last = wr_en && (wr_ptr == LAST_IDX);
    rd_en   = (state_q == READ);
    accept  = out_valid_q && out_ready;
    rd_last = accept && (rd_ptr == LAST_IDX);
    // A stall re-reads the presented index, so the memory output never
    // changes under a held pair.
    rd_addr = accept ? rd_ptr + AW'(1) : rd_ptr;
  end

  // Next-state logic. abort overrides everything, including start in IDLE.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start)   state_d = CAPTURE;
        CAPTURE: if (wr_last) state_d = READ;
        READ:    if (rd_last) state_d = IDLE;
        default:              state_d = IDLE;
      endcase
    end
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments only, so every register samples pre-edge values and the order of statements cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Write pointer: cleared when a capture starts, advanced on each stored pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if ((state_q == IDLE) && (state_d == CAPTURE)) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Readout control: presented index, output valid flag and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= rd_last && !abort;
      if (abort) begin
        rd_ptr      <= '0;
        out_valid_q <= 1'b0;
      end else if (wr_last) begin
        rd_ptr      <= '0;
        out_valid_q <= 1'b0;
      end else if (state_q == READ) begin
        if (!out_valid_q) begin
          // Index 0 was fetched on this edge; present it from now on.
          out_valid_q <= 1'b1;
        end else if (accept) begin
          if (rd_last) out_valid_q <= 1'b0;
          else         rd_ptr      <= rd_ptr + AW'(1);
        end
      end
    end
  end

  // Capture memory with registered read port.
  // NOTE: the array and its read register are not reset so they map onto block RAM; stale contents never escape because the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ref_in, fb_in};
    if (rd_en) rd_q <= mem[rd_addr];
  end

  // Outputs are forced to zero whenever no pair is being presented, which
  // also makes them drop immediately with rst_n.
  always_comb begin
    out_valid = out_valid_q;
    out_ref   = out_valid_q ? rd_q[2*W-1:W] : '0;
    out_fb    = out_valid_q ? rd_q[W-1:0]   : '0;
    out_last  = out_valid_q && (rd_ptr == LAST_IDX);
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule
